// File: rtl/time_cmd_parser_if.sv
// Bus bundle for time_cmd_parser: the UART byte stream going in, and the
// validated set-time outputs plus status coming back.
//
// Handshake: rx_valid is a one-cycle strobe meaning rx_data holds a byte this
// cycle. There is no ready signal, so the parser must take every strobed byte.
// set_valid and err are one-cycle pulses and are never high together.
// set_sel/hours/minutes/seconds hold their last accepted values between pulses.
// state_dbg mirrors the parser FSM state encoding (0 = IDLE).
interface time_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] set_sel;
  logic [5:0] set_hours;
  logic [5:0] set_minutes;
  logic [5:0] set_seconds;
  logic       set_valid;
  logic       err;
  logic       busy;
  logic [3:0] state_dbg;

  // Byte source / consumer of the set-time results.
  modport master (
    output rx_data, rx_valid,
    input  set_sel, set_hours, set_minutes, set_seconds,
    input  set_valid, err, busy, state_dbg
  );

  // The parser itself.
  modport slave (
    input  rx_data, rx_valid,
    output set_sel, set_hours, set_minutes, set_seconds,
    output set_valid, err, busy, state_dbg
  );
endinterface

// File: rtl/time_cmd_parser.sv
// time_cmd_parser: parses "<mode>HH:MM:SS<CR>" ASCII commands from the UART
// receiver and emits binary hours/minutes/seconds with a 2-bit target select
// (01 clock, 10 timer, 11 stopwatch) and a one-cycle set_valid pulse.
// Malformed bytes or out-of-range fields give a one-cycle err pulse instead.
// Optional macro TIME_CMD_TIMEOUT_EN adds an inter-byte timeout that aborts a
// partial command after TIMEOUT_CYCLES idle cycles.
module time_cmd_parser #(
  parameter int MAX_HOURS      = 23,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic               clk,
  input logic               rst,
  time_cmd_parser_if.slave  bus
);

  localparam logic [6:0] MaxHours7 = 7'(MAX_HOURS);
  localparam logic [6:0] MaxMinSec = 7'd59;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_HT   = 4'd1,
    S_HO   = 4'd2,
    S_C1   = 4'd3,
    S_MT   = 4'd4,
    S_MO   = 4'd5,
    S_C2   = 4'd6,
    S_ST   = 4'd7,
    S_SO   = 4'd8,
    S_ENDC = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_pend_q, sel_pend_d;
  logic [3:0] ht_q, ht_d, ho_q, ho_d;
  logic [3:0] mt_q, mt_d, mo_q, mo_d;
  logic [3:0] st_q, st_d, so_q, so_d;
  logic [1:0] set_sel_q, set_sel_d;
  logic [5:0] set_hours_q, set_hours_d;
  logic [5:0] set_minutes_q, set_minutes_d;
  logic [5:0] set_seconds_q, set_seconds_d;
  logic       set_valid_q, set_valid_d;
  logic       err_q, err_d;

  logic       is_digit;
  logic [3:0] digit;
  logic [6:0] hours7, minutes7, seconds7;
  logic       in_range;
  logic       bad;

`ifdef TIME_CMD_TIMEOUT_EN
  localparam int            CntW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // tens*10 + ones as 8x + 2x + ones; 99 max fits in 7 bits.
  function automatic logic [6:0] bcd2bin(input logic [3:0] t, input logic [3:0] o);
    return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, o};
  endfunction

  // Digit decode and field conversion/range check from the stored digits.
  always_comb begin
    is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    digit    = bus.rx_data[3:0];
    hours7   = bcd2bin(ht_q, ho_q);
    minutes7 = bcd2bin(mt_q, mo_q);
    seconds7 = bcd2bin(st_q, so_q);
    in_range = (hours7 <= MaxHours7) && (minutes7 <= MaxMinSec) &&
               (seconds7 <= MaxMinSec);
  end

  // Next-state logic: one byte per strobe, mismatches abort to IDLE with err.
  always_comb begin
    state_d       = state_q;
    sel_pend_d    = sel_pend_q;
    ht_d          = ht_q;
    ho_d          = ho_q;
    mt_d          = mt_q;
    mo_d          = mo_q;
    st_d          = st_q;
    so_d          = so_q;
    set_sel_d     = set_sel_q;
    set_hours_d   = set_hours_q;
    set_minutes_d = set_minutes_q;
    set_seconds_d = set_seconds_q;
    set_valid_d   = 1'b0;
    err_d         = 1'b0;
    bad           = 1'b0;

    if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          // Anything but a mode letter is line noise here and is dropped.
          case (bus.rx_data)
            8'h43:   begin sel_pend_d = 2'b01; state_d = S_HT; end
            8'h54:   begin sel_pend_d = 2'b10; state_d = S_HT; end
            8'h53:   begin sel_pend_d = 2'b11; state_d = S_HT; end
            default: ;
          endcase
        end
        S_HT: if (is_digit) begin ht_d = digit; state_d = S_HO; end else bad = 1'b1;
        S_HO: if (is_digit) begin ho_d = digit; state_d = S_C1; end else bad = 1'b1;
        S_C1: if (bus.rx_data == 8'h3A) state_d = S_MT; else bad = 1'b1;
        S_MT: if (is_digit) begin mt_d = digit; state_d = S_MO; end else bad = 1'b1;
        S_MO: if (is_digit) begin mo_d = digit; state_d = S_C2; end else bad = 1'b1;
        S_C2: if (bus.rx_data == 8'h3A) state_d = S_ST; else bad = 1'b1;
        S_ST: if (is_digit) begin st_d = digit; state_d = S_SO; end else bad = 1'b1;
        S_SO: if (is_digit) begin so_d = digit; state_d = S_ENDC; end else bad = 1'b1;
        S_ENDC: begin
          if (bus.rx_data == 8'h0D) begin
            state_d = S_IDLE;
            if (in_range) begin
              set_sel_d     = sel_pend_q;
              set_hours_d   = hours7[5:0];
              set_minutes_d = minutes7[5:0];
              set_seconds_d = seconds7[5:0];
              set_valid_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            bad = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (bad) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end

`ifdef TIME_CMD_TIMEOUT_EN
    // Timeout only fires on cycles without a byte, so it never collides with
    // a set_valid or a byte-driven err.
    cnt_d = cnt_q;
    if (bus.rx_valid || (state_q == S_IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d   = '0;
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      sel_pend_q    <= 2'b00;
      ht_q          <= 4'd0;
      ho_q          <= 4'd0;
      mt_q          <= 4'd0;
      mo_q          <= 4'd0;
      st_q          <= 4'd0;
      so_q          <= 4'd0;
      set_sel_q     <= 2'b00;
      set_hours_q   <= 6'd0;
      set_minutes_q <= 6'd0;
      set_seconds_q <= 6'd0;
      set_valid_q   <= 1'b0;
      err_q         <= 1'b0;
`ifdef TIME_CMD_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sel_pend_q    <= sel_pend_d;
      ht_q          <= ht_d;
      ho_q          <= ho_d;
      mt_q          <= mt_d;
      mo_q          <= mo_d;
      st_q          <= st_d;
      so_q          <= so_d;
      set_sel_q     <= set_sel_d;
      set_hours_q   <= set_hours_d;
      set_minutes_q <= set_minutes_d;
      set_seconds_q <= set_seconds_d;
      set_valid_q   <= set_valid_d;
      err_q         <= err_d;
`ifdef TIME_CMD_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.set_sel     = set_sel_q;
  assign bus.set_hours   = set_hours_q;
  assign bus.set_minutes = set_minutes_q;
  assign bus.set_seconds = set_seconds_q;
  assign bus.set_valid   = set_valid_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_time_cmd_parser.sv
// Directed bench for time_cmd_parser: one task per scenario, inline checks.
module tb_time_cmd_parser;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   err_cnt = 0;
  int   sv_cnt = 0;
  int   both_cnt = 0;

  time_cmd_parser_if bus ();

  time_cmd_parser #(
    .MAX_HOURS      (23),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and pulse monitor (sampled mid-cycle on the falling edge).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.err) err_cnt++;
    if (bus.set_valid) sv_cnt++;
    if (bus.err && bus.set_valid) both_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe one byte; returns #1 after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      tick(gap);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    checks++;
    if ({bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds} !== 20'h0)
      $display("FAIL reset_outputs got sel=%b h=%0d m=%0d s=%0d want all 0",
               bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds);
    else passes++;
    checks++;
    if ({bus.set_valid, bus.err, bus.busy} !== 3'b000)
      $display("FAIL reset_flags got valid/err/busy=%b want 000",
               {bus.set_valid, bus.err, bus.busy});
    else passes++;
    checks++;
    if (bus.state_dbg !== 4'd0)
      $display("FAIL reset_state got %0d want 0", bus.state_dbg);
    else passes++;
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_cnt;
    send_byte("C");
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL basic_busy got %b want 1", bus.busy);
    else passes++;
    tick(9);
    send_str("12:34:56", 9);
    send_byte(8'h0D);
    checks++;
    if (bus.set_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.set_valid);
    else passes++;
    checks++;
    if ({bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds} !==
        {2'b01, 6'd12, 6'd34, 6'd56})
      $display("FAIL basic_fields got sel=%b %0d/%0d/%0d want 01 12/34/56",
               bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds);
    else passes++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_idle got busy=%b want 0", bus.busy);
    else passes++;
    tick(1);
    checks++;
    if (bus.set_valid !== 1'b0) $display("FAIL basic_pulse_width got %b want 0", bus.set_valid);
    else passes++;
    checks++;
    if (err_cnt - e0 !== 0) $display("FAIL basic_no_err got %0d errs want 0", err_cnt - e0);
    else passes++;
  endtask

  task automatic test_range();
    int v0;
    v0 = sv_cnt;
    send_str("C24:00:00", 1);
    send_byte(8'h0D);
    checks++;
    if ({bus.err, bus.set_valid} !== 2'b10)
      $display("FAIL range_hours got err/valid=%b want 10", {bus.err, bus.set_valid});
    else passes++;
    checks++;
    if ({bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds} !==
        {2'b01, 6'd12, 6'd34, 6'd56})
      $display("FAIL range_hold got sel=%b %0d/%0d/%0d want 01 12/34/56",
               bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds);
    else passes++;
    tick(1);
    send_str("T23:60:00", 0);
    send_byte(8'h0D);
    checks++;
    if (bus.err !== 1'b1) $display("FAIL range_minutes got err=%b want 1", bus.err);
    else passes++;
    tick(1);
    send_str("S00:00:60", 0);
    send_byte(8'h0D);
    checks++;
    if (bus.err !== 1'b1) $display("FAIL range_seconds got err=%b want 1", bus.err);
    else passes++;
    tick(2);
    checks++;
    if (sv_cnt - v0 !== 0) $display("FAIL range_no_valid got %0d pulses want 0", sv_cnt - v0);
    else passes++;
    checks++;
    if ({bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds} !==
        {2'b01, 6'd12, 6'd34, 6'd56})
      $display("FAIL range_hold_end got sel=%b %0d/%0d/%0d want 01 12/34/56",
               bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = sv_cnt;
    send_str("T23:59:59", 0);
    send_byte(8'h0D);
    checks++;
    if ({bus.set_valid, bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds} !==
        {1'b1, 2'b10, 6'd23, 6'd59, 6'd59})
      $display("FAIL b2b_first got v=%b sel=%b %0d/%0d/%0d want 1 10 23/59/59",
               bus.set_valid, bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds);
    else passes++;
    // 'S' is strobed while set_valid is still high.
    send_str("S00:00:00", 0);
    send_byte(8'h0D);
    checks++;
    if ({bus.set_valid, bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds} !==
        {1'b1, 2'b11, 6'd0, 6'd0, 6'd0})
      $display("FAIL b2b_second got v=%b sel=%b %0d/%0d/%0d want 1 11 0/0/0",
               bus.set_valid, bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds);
    else passes++;
    tick(2);
    checks++;
    if (sv_cnt - v0 !== 2) $display("FAIL b2b_count got %0d pulses want 2", sv_cnt - v0);
    else passes++;
  endtask

  task automatic test_bad_char();
    int e0;
    int v0;
    send_str("C12", 0);
    e0 = err_cnt;
    send_byte("-");
    checks++;
    if ({bus.err, bus.busy} !== 2'b10)
      $display("FAIL bad_dash got err/busy=%b want 10", {bus.err, bus.busy});
    else passes++;
    tick(1);
    checks++;
    if (bus.err !== 1'b0) $display("FAIL bad_dash_width got err=%b want 0", bus.err);
    else passes++;
    v0 = sv_cnt;
    send_str("34:56", 2);
    send_byte(8'h0D);
    tick(2);
    checks++;
    if ({err_cnt - e0, sv_cnt - v0} !== {32'd1, 32'd0})
      $display("FAIL bad_tail got errs=%0d valids=%0d want 1/0", err_cnt - e0, sv_cnt - v0);
    else passes++;
    checks++;
    if (bus.busy !== 1'b0) $display("FAIL bad_tail_busy got %b want 0", bus.busy);
    else passes++;
    // A mode letter mid-command errors and is not taken as a new start.
    send_str("C1", 0);
    send_byte("T");
    checks++;
    if ({bus.err, bus.busy} !== 2'b10)
      $display("FAIL bad_mode_mid got err/busy=%b want 10", {bus.err, bus.busy});
    else passes++;
    v0 = sv_cnt;
    send_str("23:59:59", 0);
    send_byte(8'h0D);
    tick(2);
    checks++;
    if (sv_cnt - v0 !== 0) $display("FAIL bad_mode_restart got %0d valids want 0", sv_cnt - v0);
    else passes++;
    // Single-digit field: error lands on the ':' in the HO slot.
    send_str("C1", 0);
    send_byte(":");
    checks++;
    if (bus.err !== 1'b1) $display("FAIL bad_short_field got err=%b want 1", bus.err);
    else passes++;
    tick(2);
  endtask

  task automatic test_mid_reset();
    int e0;
    int v0;
    send_str("C12:3", 0);
    e0 = err_cnt;
    v0 = sv_cnt;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    checks++;
    if ({bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds,
         bus.set_valid, bus.err, bus.busy} !== 23'h0)
      $display("FAIL mreset_outputs got sel=%b %0d/%0d/%0d v/e/b=%b want all 0",
               bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds,
               {bus.set_valid, bus.err, bus.busy});
    else passes++;
    tick(1);
    send_str("C01:02:03", 0);
    send_byte(8'h0D);
    checks++;
    if ({bus.set_valid, bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds} !==
        {1'b1, 2'b01, 6'd1, 6'd2, 6'd3})
      $display("FAIL mreset_after got v=%b sel=%b %0d/%0d/%0d want 1 01 1/2/3",
               bus.set_valid, bus.set_sel, bus.set_hours, bus.set_minutes, bus.set_seconds);
    else passes++;
    tick(1);
    checks++;
    if ({err_cnt - e0, sv_cnt - v0} !== {32'd0, 32'd1})
      $display("FAIL mreset_pulses got errs=%0d valids=%0d want 0/1", err_cnt - e0, sv_cnt - v0);
    else passes++;
  endtask

  task automatic test_timeout();
    int e0;
    send_str("C12", 0);
    e0 = err_cnt;
    tick(99);
    checks++;
    if ({err_cnt - e0, 31'd0, bus.busy} !== {32'd0, 32'd1})
      $display("FAIL timeout_early got errs=%0d busy=%b want 0/1", err_cnt - e0, bus.busy);
    else passes++;
    tick(1);
`ifdef TIME_CMD_TIMEOUT_EN
    checks++;
    if ({bus.err, bus.busy} !== 2'b10)
      $display("FAIL timeout_fire got err/busy=%b want 10", {bus.err, bus.busy});
    else passes++;
    tick(1);
    checks++;
    if (bus.err !== 1'b0) $display("FAIL timeout_width got err=%b want 0", bus.err);
    else passes++;
`else
    tick(10);
    checks++;
    if ({err_cnt - e0, 31'd0, bus.busy} !== {32'd0, 32'd1})
      $display("FAIL timeout_none got errs=%0d busy=%b want 0/1", err_cnt - e0, bus.busy);
    else passes++;
`endif
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt !== 0) $display("FAIL exclusive got %0d overlap cycles want 0", both_cnt);
    else passes++;
  endtask

  // Sequencer and final report.
  initial begin
    rst          = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_bad_char();
    test_mid_reset();
    test_timeout();
    test_exclusive();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
